// File: rtl/pair_acc_pkg.sv
// Shared types and default widths for the operand-pair accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: mode_e operation select, default parameter values.
package pair_acc_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_MAX = 2'b11
    } mode_e;

    localparam int DEF_W     = 4;
    localparam int DEF_ACC_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/pair_acc_alu.sv
// Combinational arithmetic core: computes result, next accumulator and overflow for one pair.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to commit the outputs.
// Ports: a, b (W-bit unsigned operands), acc (current accumulator), mode (mode_e),
//        res_nxt (result to register), acc_nxt (accumulator to register), ovf_bit (this pair overflowed).
// Config: PAIR_ACC_SAT_EN selects clamping instead of wrap-around for SUB and ACC.
module pair_acc_alu
    import pair_acc_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [ACC_W-1:0] acc,
    input  mode_e            mode,
    output logic [ACC_W-1:0] res_nxt,
    output logic [ACC_W-1:0] acc_nxt,
    output logic             ovf_bit
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] diff;
    logic [ACC_W:0]   acc_sum;
    logic             borrow;

    assign a_ext = {{(ACC_W-W){1'b0}}, a};
    assign b_ext = {{(ACC_W-W){1'b0}}, b};
    assign diff  = a_ext - b_ext;
    assign borrow = (a < b);
    // One extra bit catches the carry; a+b never exceeds 2^ACC_W-1 because ACC_W >= W+1.
    assign acc_sum = {1'b0, acc} + {1'b0, a_ext} + {1'b0, b_ext};

    always_comb begin
        res_nxt = '0;
        acc_nxt = acc;
        ovf_bit = 1'b0;
        case (mode)
            MODE_ADD: begin
                res_nxt = a_ext + b_ext;
            end
            MODE_SUB: begin
                ovf_bit = borrow;
`ifdef PAIR_ACC_SAT_EN
                res_nxt = borrow ? '0 : diff;
`else
                res_nxt = diff;
`endif
            end
            MODE_ACC: begin
                ovf_bit = acc_sum[ACC_W];
`ifdef PAIR_ACC_SAT_EN
                acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
                acc_nxt = acc_sum[ACC_W-1:0];
`endif
                res_nxt = acc_nxt;
            end
            MODE_MAX: begin
                // Ties return a.
                res_nxt = (a >= b) ? a_ext : b_ext;
            end
            default: begin
                res_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/pair_accumulator.sv
// Operand-pair arithmetic engine with running accumulator, sticky overflow and pair counter.
// Latency: 1 cycle from accepted pair to out_valid/result.
// Backpressure: in_ready = !out_valid || out_ready; a held result freezes all state except clear.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/op_a/op_b/mode/clear on the input side;
//        out_valid/out_ready/result on the output side; ovf (sticky) and count (saturating) status.
// Config: PAIR_ACC_SAT_EN enables saturating SUB/ACC (handled inside pair_acc_alu).
module pair_accumulator
    import pair_acc_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_base;
    logic             ovf_base;
    logic [CNT_W-1:0] cnt_base;
    logic [ACC_W-1:0] alu_res;
    logic [ACC_W-1:0] alu_acc;
    logic             alu_ovf;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Clear takes effect before a same-cycle pair, so the pair sees zeroed state.
    assign acc_base = clear ? '0 : acc_q;
    assign ovf_base = clear ? 1'b0 : ovf;
    assign cnt_base = clear ? '0 : count;

    pair_acc_alu #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_alu (
        .a       (op_a),
        .b       (op_b),
        .acc     (acc_base),
        .mode    (mode_e'(mode)),
        .res_nxt (alu_res),
        .acc_nxt (alu_acc),
        .ovf_bit (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            acc_q     <= '0;
            ovf       <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            acc_q     <= alu_acc;
            ovf       <= ovf_base | alu_ovf;
            count     <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (clear) begin
                acc_q <= '0;
                ovf   <= 1'b0;
                count <= '0;
            end
        end
    end

endmodule

// File: doc/pair_accumulator.md
# pair_accumulator

Parametrised operand-pair arithmetic engine with a running accumulator, valid/ready handshakes on both sides and a one-entry output buffer. It is the multi-mode successor to the fixed nibble adder. It sits between the `ui_in` pin decode and the `uo_out` driver in the tile top level, and it supports back-pressure from downstream logic.

## Interface
- `W`, 4, operand width in bits.
- `ACC_W`, 8, result and accumulator width; must satisfy `ACC_W >= W+1`.
- `CNT_W`, 8, width of the transaction counter.
---
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `op_a`  in  W  first operand, unsigned.
- `op_b`  in  W  second operand, unsigned.
- `mode`  in  2  operation select, sampled with the operands.
- `clear`  in  1  synchronous clear of the accumulator, `ovf` and `count`.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  downstream accepts `result`.
- `result`  out  ACC_W  computed value.
- `ovf`  out  1  sticky overflow/borrow flag.
- `count`  out  CNT_W  number of pairs accepted since the last reset or clear.

## Operation
- **Accept:** a pair is accepted when `in_valid && in_ready`.
- **Ready rule:** `in_ready = !out_valid || out_ready`. Ready is combinational from `out_ready`; there is no combinational path from `in_valid`.
- **Mode 00 ADD:** `result = a + b`, zero-extended. Cannot overflow.
- **Mode 01 SUB:** `result = a - b`, two's-complement modulo 2^ACC_W. `a < b` sets `ovf`.
- **Mode 10 ACC:**
  - `acc_next = acc + a + b`, modulo 2^ACC_W.
  - `result = acc_next`.
  - A carry out of bit ACC_W-1 sets `ovf`.
- **Mode 11 MAX:** `result = max(a, b)`, zero-extended. Ties return `a`.
- **Accumulator:** changes only on an accepted mode-10 pair. All other modes leave it unchanged.
- **count:** increments on every accepted pair and saturates at all-ones.
- **clear:**
  - In a cycle with no accept: accumulator, `ovf` and `count` go to 0.
  - In a cycle with an accept: the clear is applied first. The pair then executes on `acc = 0`, `count` becomes 1, and `ovf` reflects only that pair.
  - `clear` does not affect `out_valid` or `result`.
- **ovf:** sticky; only reset or `clear` lower it.

## Timing
- **Latency:** 1 cycle. A pair accepted at edge N gives `out_valid = 1` and `result` after edge N.
- **Hold:** `result` holds stable while `out_valid && !out_ready`.
- **Hand-off:** `out_valid` drops after the edge where `out_ready` is seen, unless a new pair is accepted at that same edge. In that case `result` updates and `out_valid` stays high. This gives full throughput of 1 pair per cycle.
- **Back-pressure:** with `out_valid=1` and `out_ready=0`, `in_ready` is 0 and no state changes except through `clear`.
- **Reset values** (any edge with `rst_n=0`, including mid-transaction): `out_valid=0`, `result=0`, `ovf=0`, `count=0`, accumulator 0. A pending output is discarded.
- **After reset:** `in_ready=1` in the first cycle after reset is released.
- **Undefined inputs:** `mode` and the operands are don't-care when `in_valid=0`.

## Configuration
- **`PAIR_ACC_SAT_EN` defined:** saturating arithmetic.
  - SUB clamps to 0 when `a < b`.
  - ACC clamps both the accumulator and `result` to 2^ACC_W-1 on carry.
  - `ovf` is still set in both cases.
- **`PAIR_ACC_SAT_EN` undefined:** wrap-around arithmetic as described under Operation.

## Structure
- **Shared package `pair_acc_pkg`:**
  - `mode_e` enum: `MODE_ADD=2'b00`, `MODE_SUB=2'b01`, `MODE_ACC=2'b10`, `MODE_MAX=2'b11`.
  - Default width constants.
- **Sub-module `pair_acc_alu`:**
  - Combinational; takes `a`, `b`, `acc` and `mode`.
  - Produces the next result, the next accumulator and an overflow bit, including the saturation logic.
- **Top module:** handshake, output register, accumulator, counter and sticky flag.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `in_valid=1` → all outputs 0 and `in_ready=1` after release.
- **ADD/SUB/MAX:** defaults; ADD 15+15 → `result=30`, `ovf=0`. SUB 3-5 → `result=0xFE`, `ovf=1` (wrap build) or `result=0x00`, `ovf=1` (SAT build). MAX(7,9) → 9.
- **ACC back-to-back:** 10 pairs of (15,15) with `out_ready=1` → results 30, 60, …, 240, then 270 mod 256 = 14 on the 9th pair with `ovf=1`, then 44. `count=10`. In the SAT build the 9th and 10th results are 255.
- **Back-pressure:** `out_ready=0` for 4 cycles after one accept → `in_ready=0`, `result` stable, `count` unchanged. Raising `out_ready` with `in_valid=1` in the same cycle → new result on the next edge and `out_valid` stays 1.
- **Clear with accept:** `acc=200`, `ovf=1`, then `clear=1` with ACC(2,3) accepted → `result=5`, `ovf=0`, `count=1`.
- **Reset mid-transaction:** `out_valid=1` and `out_ready=0` when `rst_n` is asserted → `out_valid=0` and accumulator 0 after the edge.
